// File: rtl/program_loader_module.sv
// Program loader: halts the CPU at an instruction boundary, takes the shared bus,
// writes LOAD_BYTES stream bytes into RAM (MAR strobe, then RAM-in strobe per byte),
// then releases the bus and pulses a CPU reset so execution restarts from address 0.
module program_loader_module #(
  parameter int unsigned LOAD_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       hold_req,
  input  logic       hold_ack,
  output logic       bus_oe,
  output logic [7:0] bus_out,
  output logic       mai,
  output logic       mi,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitByte,
    StSetAddr,
    StWrite,
    StRelease
  } state_e;

  // Address arithmetic is 8-bit; LOAD_BYTES=256 ends at 0xFF without wrapping.
  localparam logic [7:0] LastAddr = 8'(LOAD_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       aborted_q, aborted_d;

  // State and datapath registers; async reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic; abort overrides every transition except from IDLE and RELEASE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    aborted_d = 1'b0;
    case (state_q)
      StIdle: begin
        // start together with abort is treated as no request at all
        if (start && !abort) begin
          state_d = StReq;
          addr_d  = 8'h00;
        end
      end
      StReq: begin
        if (hold_ack) begin
          state_d = StWaitByte;
        end
      end
      StWaitByte: begin
        if (s_valid) begin
          data_d  = s_data;
          state_d = StSetAddr;
        end
      end
      StSetAddr: begin
        state_d = StWrite;
      end
      StWrite: begin
        if (addr_q == LastAddr) begin
          state_d = StRelease;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = StWaitByte;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle) && (state_q != StRelease)) begin
      // a latched but unwritten byte is simply dropped
      state_d   = StIdle;
      aborted_d = 1'b1;
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    s_ready  = 1'b0;
    hold_req = 1'b0;
    bus_oe   = 1'b0;
    bus_out  = 8'h00;
    mai      = 1'b0;
    mi       = 1'b0;
    cpu_rst  = 1'b0;
    done     = 1'b0;
    case (state_q)
      StReq: begin
        hold_req = 1'b1;
      end
      StWaitByte: begin
        hold_req = 1'b1;
        s_ready  = 1'b1;
      end
      StSetAddr: begin
        hold_req = 1'b1;
        bus_oe   = 1'b1;
        bus_out  = addr_q;
        mai      = 1'b1;
      end
      StWrite: begin
        hold_req = 1'b1;
        bus_oe   = 1'b1;
        bus_out  = data_q;
        mi       = 1'b1;
      end
      StRelease: begin
        cpu_rst = 1'b1;
        done    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_program_loader_module.sv
// Bench for program_loader_module: emulates the control module (hold_ack), the MAR/RAM
// pair and the byte stream, and checks the DUT every cycle against a session-level model.
module tb_program_loader_module;

  localparam int unsigned LB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       hold_ack = 1'b0;
  logic       s_ready, hold_req, bus_oe, mai, mi, cpu_rst, busy, done, aborted;
  logic [7:0] bus_out;

  program_loader_module #(.LOAD_BYTES(LB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .hold_req (hold_req),
    .hold_ack (hold_ack),
    .bus_oe   (bus_oe),
    .bus_out  (bus_out),
    .mai      (mai),
    .mi       (mi),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- session-level reference model ----------------
  bit         m_sess = 1'b0;  // session owns (or is asking for) the bus
  bit         m_gr   = 1'b0;  // control module has granted the bus
  bit         m_fin  = 1'b0;  // completion cycle
  bit         m_abt  = 1'b0;  // abort pulse cycle
  int         m_x    = 0;     // 0 no byte in flight, 1 address phase, 2 data phase
  int         m_idx  = 0;     // index of byte in flight / next byte
  logic [7:0] m_cur  = 8'h00;
  logic [7:0] exp_ram [256];
  logic [7:0] ram [256];
  logic [7:0] mar = 8'h00;

  function automatic logic [16:0] model_out();
    logic [7:0] bo;
    bo = (m_x == 1) ? 8'(m_idx) : (m_x == 2) ? m_cur : 8'h00;
    return {m_sess & m_gr & (m_x == 0), m_sess, (m_x != 0), bo, (m_x == 1), (m_x == 2),
            m_fin, m_sess | m_fin, m_fin, m_abt};
  endfunction

  task automatic model_step();
    bit was_fin;
    was_fin = m_fin;
    m_fin = 1'b0;
    m_abt = 1'b0;
    if (was_fin) begin
    end else if (!m_sess) begin
      if (start && !abort) begin
        m_sess = 1'b1; m_gr = 1'b0; m_idx = 0; m_x = 0;
      end
    end else begin
      if (m_x == 2) exp_ram[m_idx] = m_cur;  // RAM write lands on this edge regardless
      if (abort) begin
        m_sess = 1'b0; m_x = 0; m_abt = 1'b1;
      end else if (!m_gr) begin
        m_gr = hold_ack;
      end else if (m_x == 0) begin
        if (s_valid) begin m_cur = s_data; m_x = 1; end
      end else if (m_x == 1) begin
        m_x = 2;
      end else begin
        m_x = 0;
        if (m_idx == int'(LB) - 1) begin m_sess = 1'b0; m_fin = 1'b1; end
        else m_idx++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_sess = 1'b0; m_gr = 1'b0; m_fin = 1'b0; m_abt = 1'b0; m_x = 0; m_idx = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!rst)
      check("outputs", 32'({s_ready, hold_req, bus_oe, bus_out, mai, mi, cpu_rst, busy, done,
                            aborted}), 32'(model_out()));
  end

  // MAR + RAM driven by the loader's strobes.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mai) mar = bus_out;
      if (mi) ram[mar] = bus_out;
    end
  end

  // ---------------- environment / stimulus ----------------
  int ack_delay = 0;
  bit ack_tie = 1'b0;
  int vmode = 0;
  int vcnt = 0;
  int sp = 0;
  logic [7:0] stream [256];
  bit start_pend = 1'b0;
  bit abort_pend = 1'b0;
  int abort_at = -1;
  bit abort_fired = 1'b0;
  int req_cnt = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, cpurst_cnt, abort_cnt, mai_cnt, mi_cnt;
  int first_req_cyc, first_rdy_cyc, first_mai_addr;

  task automatic reset_obs();
    busy_cnt = 0; done_cnt = 0; cpurst_cnt = 0; abort_cnt = 0; mai_cnt = 0; mi_cnt = 0;
    first_req_cyc = -1; first_rdy_cyc = -1; first_mai_addr = -1;
    sp = 0; vcnt = 0; abort_fired = 1'b0;
  endtask

  task automatic fill_stream(input bit rnd, input logic [7:0] base);
    for (int i = 0; i < 256; i++) stream[i] = rnd ? 8'($urandom) : base + 8'(i);
  endtask

  // One cycle: observe outputs mid-cycle, then drive the inputs for the next edge.
  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (cpu_rst) cpurst_cnt++;
    if (aborted) abort_cnt++;
    if (mai) mai_cnt++;
    if (mi) mi_cnt++;
    if (hold_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (s_ready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
    if (mai && first_mai_addr < 0) first_mai_addr = int'(bus_out);
    req_cnt  = hold_req ? req_cnt + 1 : 0;
    hold_ack = ack_tie || (hold_req && req_cnt > ack_delay);
    vcnt++;
    case (vmode)
      0:       s_valid = 1'b1;
      1:       s_valid = (vcnt % 4 == 0);
      default: s_valid = 1'($urandom_range(0, 1));
    endcase
    s_data = s_valid ? stream[sp & 255] : 8'($urandom);
    if (s_ready && s_valid) sp++;
    abort = abort_pend;
    if (abort_at >= 0 && mai && int'(bus_out) == abort_at) begin
      abort = 1'b1; abort_fired = 1'b1; abort_at = -1;
    end
    start = start_pend;
    start_pend = 1'b0;
    abort_pend = 1'b0;
  endtask

  task automatic run_session(input int bound, input int extra_start_at);
    start_pend = 1'b1;
    tick();
    for (int i = 0; i < bound; i++) begin
      if (i == extra_start_at) start_pend = 1'b1;
      tick();
      if (!busy) break;
    end
    check("session_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic compare_ram(input string name);
    for (int i = 0; i < int'(LB); i++) check(name, 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; exp_ram[i] = 8'h00; end
    reset_obs();
    #12;
    check("reset_outputs", 32'({s_ready, hold_req, bus_oe, bus_out, mai, mi, cpu_rst, busy,
                                done, aborted}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Straight load: ack tied high, stream 0x10.. always valid.
    ack_tie = 1'b1; vmode = 0; fill_stream(1'b0, 8'h10); reset_obs();
    run_session(200, -1);
    check("full_busy_cycles", 32'(busy_cnt), 32'd50);
    check("full_done_pulses", 32'(done_cnt), 32'd1);
    check("full_cpurst_pulses", 32'(cpurst_cnt), 32'd1);
    check("full_no_abort", 32'(abort_cnt), 32'd0);
    for (int i = 0; i < int'(LB); i++) check("full_ram_lit", 32'(ram[i]), 32'h10 + 32'(i));
    compare_ram("full_ram_model");
    ack_tie = 1'b0;
    tick(); tick();

    // Delayed grant.
    ack_delay = 7; fill_stream(1'b1, 8'h00); reset_obs();
    run_session(300, -1);
    check("ack_delay_ready_lag", 32'(first_rdy_cyc - first_req_cyc), 32'd8);
    check("ack_delay_done", 32'(done_cnt), 32'd1);
    compare_ram("ack_delay_ram");

    // Stream with gaps: valid every 4th cycle.
    ack_delay = 0; vmode = 1; fill_stream(1'b1, 8'h00); reset_obs();
    run_session(400, -1);
    check("gap_mai_count", 32'(mai_cnt), 32'd16);
    check("gap_mi_count", 32'(mi_cnt), 32'd16);
    check("gap_done", 32'(done_cnt), 32'd1);
    compare_ram("gap_ram");

    // Abort in SET_ADDR of byte 5.
    for (int i = 0; i < 256; i++) begin ram[i] = 8'hEE; exp_ram[i] = 8'hEE; end
    vmode = 0; fill_stream(1'b1, 8'h00); reset_obs();
    abort_at = 5;
    start_pend = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (abort_fired) break;
    end
    check("abort_reached", 32'(abort_fired), 32'd1);
    tick();
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_busy_low", 32'(busy), 32'd0);
    tick();
    check("abort_single_pulse", 32'(abort_cnt), 32'd1);
    check("abort_no_cpurst", 32'(cpurst_cnt), 32'd0);
    check("abort_ram5_kept", 32'(ram[5]), 32'hEE);
    for (int i = 0; i < 5; i++) check("abort_ram_written", 32'(ram[i]), 32'(stream[i]));
    compare_ram("abort_ram_model");
    fill_stream(1'b1, 8'h00); reset_obs();
    run_session(200, -1);
    check("restart_addr0", 32'(first_mai_addr), 32'd0);
    check("restart_done", 32'(done_cnt), 32'd1);
    compare_ram("restart_ram");

    // start during a session is ignored.
    fill_stream(1'b0, 8'h40); reset_obs();
    run_session(200, 10);
    check("midstart_busy_cycles", 32'(busy_cnt), 32'd50);
    check("midstart_done", 32'(done_cnt), 32'd1);
    compare_ram("midstart_ram");

    // start+abort together in IDLE does nothing.
    reset_obs();
    start_pend = 1'b1; abort_pend = 1'b1;
    repeat (5) tick();
    check("startabort_busy", 32'(busy_cnt), 32'd0);
    check("startabort_aborted", 32'(abort_cnt), 32'd0);

    // Asynchronous reset in the middle of a WRITE cycle.
    fill_stream(1'b1, 8'h00); reset_obs();
    start_pend = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mai && bus_out == 8'd2) break;
    end
    check("rst_reached_setaddr", 32'(mai), 32'd1);
    @(posedge clk);
    #1;
    check("rst_pre_mi", 32'(mi), 32'd1);
    check("rst_pre_bus_oe", 32'(bus_oe), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_bus_oe", 32'(bus_oe), 32'd0);
    check("rst_async_mi", 32'(mi), 32'd0);
    check("rst_async_hold_req", 32'(hold_req), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_after_busy", 32'(busy), 32'd0);
    compare_ram("rst_ram");

    // Randomized sessions.
    for (int k = 0; k < 4; k++) begin
      vmode = 2; ack_delay = int'($urandom_range(0, 4));
      fill_stream(1'b1, 8'h00); reset_obs();
      run_session(600, int'($urandom_range(0, 30)));
      check("rand_done", 32'(done_cnt), 32'd1);
      compare_ram("rand_ram");
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader_module.md
# program_loader_module

Bus-sharing controller that loads a program image into the 8-bit computer's RAM from an external byte stream. On request it asks the control module to halt at an instruction boundary, then takes ownership of the shared 8-bit bus. It drives the memory address register and RAM input strobes once per byte. When the image is written it releases the bus and pulses a CPU reset so execution starts from the program counter's reset value.

## Interface

Parameters:
- LOAD_BYTES, 16: bytes per load session; RAM addresses 0 .. LOAD_BYTES-1; legal range 1..256.

Ports:
- clk  in  1  system clock (the gated clock from clock_module).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a load session.
- abort  in  1  cancel an active session.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte this cycle.
- hold_req  out  1  request the control module to stop sequencing and release the bus.
- hold_ack  in  1  control module is halted at a fetch boundary with all bus drivers off.
- bus_oe  out  1  loader drives the shared bus.
- bus_out  out  8  value driven onto the bus when bus_oe = 1, else 0.
- mai  out  1  strobe OR'd into ctrl[MAI].
- mi  out  1  strobe OR'd into ctrl[MI].
- cpu_rst  out  1  one-cycle reset pulse to program counter and output register.
- busy  out  1  session active (state ≠ IDLE).
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse on abort.

## Operation

- Moore FSM with states IDLE, REQ, WAIT_BYTE, SET_ADDR, WRITE, RELEASE. All outputs are decoded from registered state and flags; no combinational path from inputs to outputs.
- Registers:
  - addr_q (8 bits): next RAM address; cleared on entry to REQ.
  - data_q (8 bits): captured byte.
- IDLE: outputs low.
  - start=1 and abort=0 -> REQ.
- REQ: hold_req=1.
  - hold_ack=1 -> WAIT_BYTE.
  - Waits indefinitely otherwise.
- WAIT_BYTE: hold_req=1, s_ready=1.
  - s_valid=1 -> data_q ← s_data, then SET_ADDR.
- SET_ADDR: hold_req=1, bus_oe=1, bus_out=addr_q, mai=1 -> WRITE.
- WRITE: hold_req=1, bus_oe=1, bus_out=data_q, mi=1.
  - If addr_q = LOAD_BYTES-1 -> RELEASE.
  - Otherwise addr_q ← addr_q+1, then WAIT_BYTE.
- RELEASE: hold_req=0, bus_oe=0, cpu_rst=1, done=1 -> IDLE.
- Abort:
  - abort=1 in any state other than IDLE or RELEASE -> IDLE next cycle.
  - aborted=1 for that one cycle (registered).
  - cpu_rst is not pulsed.
  - RAM keeps the bytes already written.
  - A byte latched but not yet written is discarded.
- abort in RELEASE is ignored, so completion wins.
- start while busy=1 is ignored.
- start and abort in the same IDLE cycle: remain IDLE, no aborted pulse.
- hold_ack falling after REQ is not checked. The control module guarantees it stays high while hold_req=1.
- Address arithmetic is 8-bit unsigned. With LOAD_BYTES=256 the last address is 0xFF and the session ends without wrapping.
- bus_oe must never be 1 while hold_ack=0. The FSM guarantees this by construction (SET_ADDR/WRITE are reachable only via REQ with hold_ack=1).

## Timing

- Reset: state=IDLE, addr_q=0, data_q=0. All outputs 0 (s_ready, hold_req, bus_oe, bus_out, mai, mi, cpu_rst, busy, done, aborted).
- start sampled at edge N -> hold_req=1 and busy=1 from cycle N+1.
- hold_ack seen at edge M -> s_ready=1 from cycle M+1.
- Per byte, minimum 3 cycles: accept edge, SET_ADDR cycle, WRITE cycle.
  - MAR loads addr_q on the edge ending SET_ADDR.
  - RAM writes on the edge ending WRITE.
- s_ready is low in SET_ADDR and WRITE. s_data/s_valid are don't-care there.
- Full session, with ack immediate and stream always valid: 1 (REQ) + 3·LOAD_BYTES + 1 (RELEASE) cycles from first busy to busy low.
- done and cpu_rst are high in the same single cycle, and busy is still high in that cycle. busy=0 the following cycle.
- Asynchronous rst mid-session: immediately IDLE with all outputs 0, releasing the bus in the same cycle.

## Test plan

- Reset mid-WRITE (async, between edges) -> bus_oe, mi, hold_req drop to 0 without a clock edge; after release, IDLE with busy=0.
- LOAD_BYTES=16, hold_ack tied 1, stream 0x10..0x1F continuously valid:
  - RAM[0..15] = 0x10..0x1F.
  - 50 cycles from start to busy low.
  - Exactly one done/cpu_rst pulse.
- hold_ack delayed 7 cycles after hold_req -> s_ready stays 0 and bus_oe 0 until one cycle after hold_ack rises; the load then completes normally.
- Stream with s_valid gaps (valid every 4th cycle) -> each byte is written exactly once in order; no mai/mi while waiting; s_ready held high in WAIT_BYTE.
- abort asserted in SET_ADDR of byte 5 -> aborted pulse, busy=0 next cycle, RAM[0..4] written, RAM[5] unchanged, no cpu_rst. A subsequent start restarts at address 0.
- start pulsed during an active session, and start+abort together in IDLE -> both are ignored: the session is unaffected, and no session or pulse is generated from IDLE.
